kmap_truth_table_scanner: RTL and testbench

//  Sequential reader for a combinational K-map function block (e.g. kmap, F(A,B,C)).

---
 rtl/kmap_pkg.sv | 14 +
 rtl/kmap_truth_table_scanner_if.sv | 25 ++
 rtl/kmap_settle_timer.sv | 28 ++
 rtl/kmap_truth_table_scanner.sv | 122 ++++++++++++
 tb/tb_kmap_truth_table_scanner.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kmap_pkg.sv
// rtl/kmap_pkg.sv - shared types and constants for the K-map truth-table scanner
package kmap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } scan_state_t;

    // Table of F = A(B'+C) + A'BC' + B'C, minterms 1,2,4,5,7
    localparam logic [7:0] KMAP_F_EXPECTED = 8'hB6;

endpackage

// File: rtl/kmap_truth_table_scanner_if.sv
// rtl/kmap_truth_table_scanner_if.sv - scan control, function-block and result handshake bundle
interface kmap_truth_table_scanner_if #(
    parameter int N_VARS = 3
);
    logic                   start;
    logic [N_VARS-1:0]      vars_out;
    logic                   f_in;
    logic [2**N_VARS-1:0]   expected_table;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ready;
    logic [2**N_VARS-1:0]   truth_table;
    logic [N_VARS:0]        minterm_cnt;
    logic                   match;

    modport slave (
        input  start, f_in, expected_table, result_ready,
        output vars_out, busy, result_valid, truth_table, minterm_cnt, match
    );

    modport master (
        output start, f_in, expected_table, result_ready,
        input  vars_out, busy, result_valid, truth_table, minterm_cnt, match
    );
endinterface

// File: rtl/kmap_settle_timer.sv
// rtl/kmap_settle_timer.sv - loadable down-counter timing how long each vector is held
module kmap_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);
    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    // Loading SETTLE_CYCLES-1 makes expiry coincide with the last hold cycle
    localparam logic [CW-1:0] PRESET = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= PRESET;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);
endmodule

// File: rtl/kmap_truth_table_scanner.sv
// rtl/kmap_truth_table_scanner.sv - sweeps all input vectors of a combinational function and captures its truth table
module kmap_truth_table_scanner
    import kmap_pkg::*;
#(
    parameter int N_VARS        = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    kmap_truth_table_scanner_if.slave    bus
);
    localparam int TBL_W = 2**N_VARS;
    localparam logic [N_VARS-1:0] LAST_IDX = '1;

    scan_state_t        r_state;
    scan_state_t        w_next;
    logic               w_load;
    logic               w_dec;
    logic               w_sample;
    logic               w_clear;
    logic               w_expired;
    logic               w_last;
    logic [N_VARS-1:0]  r_index;
    logic [TBL_W-1:0]   r_table;
    logic [TBL_W-1:0]   w_table_next;
    logic [N_VARS:0]    r_cnt;
    logic               r_match;

    kmap_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_dec     (w_dec),
        .o_expired (w_expired)
    );

    assign w_last = (r_index == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_sample = 1'b0;
        w_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next  = DRIVE;
                    w_clear = 1'b1;
                    w_load  = 1'b1;
                end
            end
            DRIVE: begin
                if (w_expired) begin
                    w_next = SAMPLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            SAMPLE: begin
                w_sample = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = DRIVE;
                    w_load = 1'b1;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The final sample must be folded in before the match compare
    always_comb begin
        w_table_next          = r_table;
        w_table_next[r_index] = bus.f_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= '0;
            r_table <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
        end else if (w_clear) begin
            r_index <= '0;
            r_table <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
        end else if (w_sample) begin
            r_table <= w_table_next;
            r_cnt   <= r_cnt + {{N_VARS{1'b0}}, bus.f_in};
            if (w_last) begin
                r_match <= (w_table_next == bus.expected_table);
            end else begin
                r_index <= r_index + {{(N_VARS-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.vars_out     = r_index;
    assign bus.busy         = (r_state != IDLE);
    assign bus.result_valid = (r_state == DONE);
    assign bus.truth_table  = r_table;
    assign bus.minterm_cnt  = r_cnt;
    assign bus.match        = r_match;
endmodule

// File: tb/tb_kmap_truth_table_scanner.sv
// tb/tb_kmap_truth_table_scanner.sv - self-checking bench for kmap_truth_table_scanner
module tb_kmap_truth_table_scanner;
    import kmap_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    kmap_truth_table_scanner_if #(.N_VARS(3)) if1 ();
    kmap_truth_table_scanner_if #(.N_VARS(3)) if3 ();

    kmap_truth_table_scanner #(.N_VARS(3), .SETTLE_CYCLES(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (if1.slave)
    );
    kmap_truth_table_scanner #(.N_VARS(3), .SETTLE_CYCLES(3)) dut3 (
        .clk (clk), .rst_n (rst_n), .bus (if3.slave)
    );

    int checks   = 0;
    int failures = 0;
    int mode1, mode3, dsel;
    logic [7:0] rt1, rt3;
    int vlog [0:511];

    // mode 0: the K-map function, 1: const 0, 2: const 1, 3: c input, other: lookup table
    function automatic logic fval(input int mode, input logic [2:0] v, input logic [7:0] t);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        case (mode)
            0:       return (a & (~b | c)) | (~a & b & ~c) | (~b & c);
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return c;
            default: return t[v];
        endcase
    endfunction

    function automatic logic [7:0] model_tbl(input int mode, input logic [7:0] t);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = fval(mode, 3'(i), t);
        return r;
    endfunction

    function automatic int popcount(input logic [7:0] t);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(t[i]);
        return n;
    endfunction

    always_comb begin
        if1.f_in = fval(mode1, if1.vars_out, rt1);
        if3.f_in = fval(mode3, if3.vars_out, rt3);
    end

    logic       o_valid, o_busy, o_match;
    logic [7:0] o_tbl;
    logic [3:0] o_cnt;
    logic [2:0] o_vars;
    always_comb begin
        if (dsel == 3) begin
            o_valid = if3.result_valid; o_busy = if3.busy; o_match = if3.match;
            o_tbl = if3.truth_table; o_cnt = if3.minterm_cnt; o_vars = if3.vars_out;
        end else begin
            o_valid = if1.result_valid; o_busy = if1.busy; o_match = if1.match;
            o_tbl = if1.truth_table; o_cnt = if1.minterm_cnt; o_vars = if1.vars_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (dsel == 3) if3.start = v; else if1.start = v;
    endtask

    task automatic set_ready(input logic v);
        if (dsel == 3) if3.result_ready = v; else if1.result_ready = v;
    endtask

    // lat = posedges from the start-accept edge until result_valid is seen
    task automatic scan(output int lat);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        lat = 0;
        chk("scan_busy", o_busy, 1'b1);
        while (!o_valid && lat < 400) begin
            vlog[lat] = int'(o_vars);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] tbl, input logic [7:0] expv,
                                input int lat, input int settle);
        chk({tag, "_lat"},   lat, 8 * (settle + 1));
        chk({tag, "_valid"}, o_valid, 1'b1);
        chk({tag, "_tbl"},   o_tbl, tbl);
        chk({tag, "_cnt"},   o_cnt, popcount(tbl));
        chk({tag, "_match"}, o_match, (tbl == expv));
    endtask

    task automatic handshake(input string tag);
        set_ready(1'b1);
        @(negedge clk);
        set_ready(1'b0);
        chk({tag, "_hs_valid"}, o_valid, 1'b0);
        chk({tag, "_hs_busy"},  o_busy, 1'b0);
    endtask

    initial begin
        int lat, bad, waited;
        int hold [0:7];
        logic [7:0] expv, mt;

        rst_n = 1'b0;
        dsel = 1; mode1 = 0; mode3 = 3; rt1 = '0; rt3 = '0;
        if1.start = 1'b0; if1.result_ready = 1'b0; if1.expected_table = '0;
        if3.start = 1'b0; if3.result_ready = 1'b0; if3.expected_table = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_busy",  o_busy, 1'b0);
        chk("rst_tbl",   o_tbl, 8'h00);
        chk("rst_cnt",   o_cnt, 4'd0);
        chk("rst_match", o_match, 1'b0);
        chk("rst_vars",  o_vars, 3'd0);
        chk("rst3_busy", if3.busy, 1'b0);
        rst_n = 1'b1;

        // K-map function against its own expected image
        mode1 = 0; if1.expected_table = KMAP_F_EXPECTED;
        scan(lat);
        check_result("t1", model_tbl(0, 8'h00), 8'hB6, lat, 1);
        chk("t1_tbl_lit", o_tbl, 8'hB6);
        chk("t1_cnt_lit", o_cnt, 4'd5);
        handshake("t1");

        // Stuck-at-0 function
        mode1 = 1;
        scan(lat);
        check_result("t2", 8'h00, 8'hB6, lat, 1);
        chk("t2_match_lit", o_match, 1'b0);
        handshake("t2");

        // Random functions, expected image matching or random
        for (int k = 0; k < 4; k++) begin
            rt1 = 8'($urandom);
            expv = ($urandom_range(0, 1) == 1) ? rt1 : 8'($urandom);
            if1.expected_table = expv;
            mode1 = 4;
            scan(lat);
            check_result("rnd", model_tbl(4, rt1), expv, lat, 1);
            handshake("rnd");
        end

        // Longer settle: every vector held SETTLE_CYCLES+1 cycles
        dsel = 3; mode3 = 3; if3.expected_table = 8'hAA;
        scan(lat);
        check_result("t3", model_tbl(3, 8'h00), 8'hAA, lat, 3);
        chk("t3_tbl_lit", o_tbl, 8'hAA);
        for (int v = 0; v < 8; v++) hold[v] = 0;
        bad = 0;
        for (int c = 0; c < lat && c < 512; c++) begin
            if (vlog[c] != c / 4) bad++;
            if (vlog[c] >= 0 && vlog[c] < 8) hold[vlog[c]]++;
        end
        chk("t3_order", bad, 0);
        for (int v = 0; v < 8; v++) chk("t3_hold", hold[v], 4);
        handshake("t3");
        dsel = 1;

        // Stalled consumer with a stray start during DONE
        mode1 = 4; rt1 = 8'($urandom); if1.expected_table = rt1;
        mt = model_tbl(4, rt1);
        scan(lat);
        check_result("t4", mt, rt1, lat, 1);
        for (int k = 0; k < 10; k++) begin
            set_start(k == 3);
            @(negedge clk);
            chk("t4_hold_valid", o_valid, 1'b1);
            chk("t4_hold_tbl",   o_tbl, mt);
            chk("t4_hold_cnt",   o_cnt, popcount(mt));
            chk("t4_hold_match", o_match, 1'b1);
            chk("t4_hold_vars",  o_vars, 3'd7);
        end
        set_start(1'b0);
        handshake("t4");
        @(negedge clk);
        chk("t4_no_restart", o_busy, 1'b0);
        chk("t4_tbl_kept",   o_tbl, mt);

        // Asynchronous reset mid-scan
        mode1 = 0; if1.expected_table = KMAP_F_EXPECTED;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        waited = 0;
        while (o_vars != 3'd4 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("t5_reach4", o_vars, 3'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", o_valid, 1'b0);
        chk("t5_busy",  o_busy, 1'b0);
        chk("t5_tbl",   o_tbl, 8'h00);
        chk("t5_cnt",   o_cnt, 4'd0);
        chk("t5_vars",  o_vars, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        scan(lat);
        check_result("t5", 8'hB6, 8'hB6, lat, 1);
        handshake("t5");

        // start held high: back-to-back scans one IDLE cycle apart
        mode1 = 2; if1.expected_table = 8'hFF;
        @(negedge clk);
        set_start(1'b1);
        set_ready(1'b1);
        @(negedge clk);
        lat = 0;
        for (int s = 0; s < 2; s++) begin
            while (!o_valid && lat < 400) begin
                @(negedge clk);
                lat++;
            end
            chk("t6_lat",   lat, 16);
            chk("t6_tbl",   o_tbl, model_tbl(2, 8'h00));
            chk("t6_cnt",   o_cnt, 4'd8);
            chk("t6_match", o_match, 1'b1);
            @(negedge clk);
            chk("t6_idle_busy",  o_busy, 1'b0);
            chk("t6_idle_valid", o_valid, 1'b0);
            @(negedge clk);
            chk("t6_restart", o_busy, 1'b1);
            lat = 0;
        end
        set_start(1'b0);
        waited = 0;
        while (o_busy && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("t6_drain", o_busy, 1'b0);
        set_ready(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
